// File: rtl/fs_pkg.sv
// Shared filesystem-port definitions: widths, well-known path words, arbiter states.
package fs_pkg;

  localparam int unsigned FS_DW = 32;
  localparam int unsigned FS_AW = 32;

  // Four-character path components packed big-endian into one filename word.
  localparam logic [FS_DW-1:0] FS_PATH_DEV  = 32'h2f64_6576;  // "/dev"
  localparam logic [FS_DW-1:0] FS_PATH_MEM  = 32'h2f6d_656d;  // "/mem"
  localparam logic [FS_DW-1:0] FS_PATH_META = 32'h6d65_7461;  // "meta"

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } fs_arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request after the last winner, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  sel,
  output logic [IW-1:0] sel_idx,
  output logic          any
);

  // Scan last+1, last+2, ... and keep only the first hit.
  always_comb begin
    int unsigned idx;
    sel     = '0;
    sel_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      if (!any && req[IW'(idx)]) begin
        any            = 1'b1;
        sel[IW'(idx)]  = 1'b1;
        sel_idx        = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fs_port_arbiter.sv
// Session-locked round-robin arbiter sharing one filesystem port among NREQ requesters.
module fs_port_arbiter
  import fs_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = FS_AW,
  parameter int unsigned DW   = FS_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_access,
  input  logic [NREQ-1:0]    req_rden,
  input  logic [NREQ-1:0]    req_wren,
  input  logic [NREQ*DW-1:0] req_filename,
  input  logic [NREQ*AW-1:0] req_address,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_grant,
  output logic [DW-1:0]      req_q,
  output logic [NREQ-1:0]    req_q_valid,
  output logic               fs_rden,
  output logic               fs_wren,
  output logic [DW-1:0]      fs_filename,
  output logic [AW-1:0]      fs_address,
  output logic [DW-1:0]      fs_data,
  input  logic [DW-1:0]      fs_q,
  output logic               fs_busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  fs_arb_state_e   state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   own_idx;
  logic [NREQ-1:0] pick_sel;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req     (req_access),
    .last    (last),
    .sel     (pick_sel),
    .sel_idx (pick_idx),
    .any     (pick_any)
  );

  // Read data is broadcast; requesters qualify it with their req_q_valid bit.
  assign req_q = fs_q;

  // Session FSM with registered port outputs and read-valid tagging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= IW'(NREQ - 1);
      own_idx     <= '0;
      req_grant   <= '0;
      req_q_valid <= '0;
      fs_rden     <= 1'b0;
      fs_wren     <= 1'b0;
      fs_filename <= '0;
      fs_address  <= '0;
      fs_data     <= '0;
      fs_busy     <= 1'b0;
    end else begin
      // fs_rden is only ever high while the grant is held, so the grant names the issuer.
      req_q_valid <= fs_rden ? req_grant : '0;
      case (state)
        IDLE: begin
          fs_rden     <= 1'b0;
          fs_wren     <= 1'b0;
          fs_filename <= '0;
          fs_address  <= '0;
          fs_data     <= '0;
          if (pick_any) begin
            req_grant <= pick_sel;
            last      <= pick_idx;
            own_idx   <= pick_idx;
            fs_busy   <= 1'b1;
            state     <= OWN;
          end
        end
        OWN: begin
          if (!req_access[own_idx]) begin
            req_grant   <= '0;
            fs_rden     <= 1'b0;
            fs_wren     <= 1'b0;
            fs_filename <= '0;
            fs_address  <= '0;
            fs_data     <= '0;
            fs_busy     <= 1'b0;
            state       <= GAP;
          end else begin
            fs_wren     <= req_wren[own_idx];
            fs_rden     <= req_rden[own_idx] & ~req_wren[own_idx];
            fs_filename <= req_filename[32'(own_idx)*DW +: DW];
            fs_address  <= req_address[32'(own_idx)*AW +: AW];
            fs_data     <= req_data[32'(own_idx)*DW +: DW];
          end
        end
        GAP: begin
          // One idle cycle with filename 0 lets the device reset its path decoder.
          fs_rden     <= 1'b0;
          fs_wren     <= 1'b0;
          fs_filename <= '0;
          fs_address  <= '0;
          fs_data     <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fs_port_arbiter.md
Name: fs_port_arbiter

Overview:
- Shares the single filesystem port (filename/address/data/rden/wren out, q in) between NREQ requesters, e.g. two paged RAM instances plus a CPU file-syscall unit.
- Grants the port to one requester at a time and holds (locks) the grant for its whole session, since a session spans many cycles of filename sequencing plus read/write bursts.
- Registers all port outputs and routes read data back with a valid strobe.
- Sits between the requesters' fsAccess/fs* bundles and the filesystem device.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 32, fs address width
DW, 32, fs data/filename width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_access  in  NREQ  per-requester session request (the requester's fsAccess)
req_rden  in  NREQ  per-requester read strobe
req_wren  in  NREQ  per-requester write strobe
req_filename  in  NREQ*DW  packed filenames, requester i at [i*DW +: DW]
req_address  in  NREQ*AW  packed addresses
req_data  in  NREQ*DW  packed write data
req_grant  out  NREQ  one-hot (or zero) current owner
req_q  out  DW  read data, broadcast to all requesters
req_q_valid  out  NREQ  one-hot strobe: req_q is valid for that requester
fs_rden  out  1  to device
fs_wren  out  1  to device
fs_filename  out  DW  to device
fs_address  out  AW  to device
fs_data  out  DW  to device
fs_q  in  DW  device read data, valid the cycle after fs_rden is high at a clk edge
fs_busy  out  1  high while any grant is held

Behaviour:
- Reset (async, rst_n=0):
  - req_grant=0, fs_* outputs=0, req_q_valid=0, fs_busy=0.
  - State IDLE; round-robin pointer last=NREQ-1, so requester 0 wins first.
  - The state takes effect immediately. Reset mid-session aborts the session with no further fs strobes.
- States: IDLE, OWN, GAP.
- IDLE:
  - If any req_access bit is high, select the first set bit scanning last+1, last+2, … modulo NREQ.
  - Next edge: req_grant=onehot(sel), last=sel, fs_busy=1, state OWN.
  - If no request, stay in IDLE with fs_* held at 0.
- OWN (owner g):
  - Each edge registers fs_filename/fs_address/fs_data from requester g's slices.
  - fs_wren=req_wren[g]. fs_rden=req_rden[g] & ~req_wren[g]; write wins, and the read is dropped if both are set.
  - Strobes, data and access from non-owners are ignored. Non-owners simply wait; there are no pending flags.
  - If req_access[g]=0 at an edge: req_grant=0, all fs_* =0, fs_busy=0, state GAP. This is the release.
- GAP:
  - Exactly one cycle with all fs_* at 0, so the device sees filename 0 and resets its path decoder, then state IDLE.
  - Arbitration happens only in IDLE, so consecutive grants are separated by at least 2 cycles of zero outputs.
- Latency:
  - Requester strobe to fs strobe: 1 cycle.
  - Read data path: req_q = fs_q (combinational).
  - req_q_valid[g] = fs_rden registered one cycle, tagged with the owner at the time fs_rden was issued. It asserts even if the owner released in the meantime.
  - Requester rden to q_valid: 2 cycles.
- Fairness: the pointer updates on every grant. A requester holding req_access continuously is granted within NREQ sessions.
- Simultaneous events:
  - Release and another requester's new request on the same edge: the other requester is granted only after GAP → IDLE → grant.
  - The owner re-raising req_access during GAP competes normally in IDLE.
- Address/data are passed through unmodified; there is no width conversion.

Decomposition:
- Shared package fs_pkg: FS_DW=32, FS_AW=32, path constants "/dev", "/mem", "meta", and the state encoding {IDLE, OWN, GAP}.
- Sub-module rr_pick: combinational rotating-priority encoder (req vector, last pointer → one-hot select, any). It is reused by other arbiters.

Test Plan:
- Reset, then only req_access[0]=1 → grant=01 on the next edge. With req_rden[0]=1 and address 0x1000: fs_rden=1 and fs_address=0x1000 one cycle later; req_q_valid=01 with req_q=fs_q one cycle after that.
- req_access=11 asserted together from reset → grant 01 first. When 0 releases: one cycle of GAP with fs_* = 0, then IDLE, then grant=10 on the following edge.
- Owner 1 holds the session; requester 0 toggles rden/wren with address 0xDEAD → fs_* reflect only requester 1's values, and fs_address never equals 0xDEAD.
- Owner asserts rden and wren together with data 0x55 → fs_wren=1, fs_rden=0, fs_data=0x55, and no req_q_valid pulse.
- Both requesters continuously requesting, each releasing after 4 cycles → grants alternate 0,1,0,1; no requester is granted twice in a row.
- rst_n pulsed low mid-OWN with fs_rden=1 → all outputs are 0 immediately (asynchronously). After release, requester 0 wins first again.
